universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//   WIDTH-bit universal shift register: hold, shift right, shift left or parallel load, chosen by a 2-bit mode.
//   General-purpose datapath element for serializers, deserializers and bit-manipulation pipelines.
//   Single clock domain; every state change is registered.
// PARAMETERS
//   WIDTH  4  register width in bits; legal range WIDTH >= 2
// PORTS
//   clk              in   1      clock; rising-edge active
//   rst              in   1      reset; asynchronous, active-low
//   serial_in_left   in   1      serial data entering at q[0] during shift left
//   serial_in_right  in   1      serial data entering at q[WIDTH-1] during shift right
//   parallel_load    in   WIDTH  data loaded in mode 2'b11
//   mode             in   2      operation select; see BEHAVIOUR
//   q                out  WIDTH  register contents
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - Reset: rst low forces q = 0 immediately, independent of clk.
//     - q holds 0 while rst is low.
//     - The first operation takes effect at the first rising clk edge after rst goes high.
//   - On each rising clk edge with rst high, the operation is selected by mode:
//     - 2'b00 hold:        q <= q
//     - 2'b01 shift right: q <= {serial_in_right, q[WIDTH-1:1]}; q[0] is discarded
//     - 2'b10 shift left:  q <= {q[WIDTH-2:0], serial_in_left}; q[WIDTH-1] is discarded
//     - 2'b11 load:        q <= parallel_load
//   - Latency: 1 clock.
//     - Inputs are sampled at the rising edge.
//     - q updates right after that edge and is stable for the whole following cycle.
//   - Unused inputs are ignored:
//     - Serial inputs have no effect in hold and load.
//     - parallel_load has no effect except in load.
//   - No handshake. An operation happens every cycle; hold is the only way to keep q unchanged.
//   - Reset mid-operation: an rst assertion overrides any mode at any time, with no clock edge needed.
//   - mode of X/Z is not a legal input. In simulation q must go X; no recovery behaviour is defined.
//   - q is driven only by the register, with no combinational path from the inputs.
// CONFIGURATION
//   USR_SERIAL_OUT_EN defined:
//     - Adds output ports serial_out_left (1 bit, = q[WIDTH-1]) and serial_out_right (1 bit, = q[0]).
//     - Both are pure combinational taps of the register and are 0 during reset.
//     - They expose the bit that the next shift left or shift right will discard, for cascading stages.
//   USR_SERIAL_OUT_EN undefined:
//     - Neither port exists.
//     - All other behaviour is identical.
// TESTING
//   1. rst low with any inputs -> q = 4'b0000 with no clock edge; q stays 0 across edges while rst is low.
//   2. rst high, mode=11, parallel_load=0010 -> q = 0010; next cycle mode=00 -> q stays 0010.
//   3. From 0010, mode=10, serial_in_left=1 -> q = 0101; one more edge -> q = 1011.
//   4. From 1011, mode=01, serial_in_right=0 -> q = 0101; one more edge -> q = 0010.
//   5. mode=11, parallel_load=0110 -> q = 0110. Then mode=01, serial_in_right=1 -> q = 1011.
//   6. Assert rst between edges while shifting -> q = 0000 immediately. Release -> operations resume from 0000.
//      With USR_SERIAL_OUT_EN defined, check serial_out_left/right against q[3]/q[0] throughout.

Source files
------------

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel load by 2-bit mode.
// Optional cascade taps serial_out_left/serial_out_right are enabled by defining USR_SERIAL_OUT_EN.
module universal_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_load,
  input  logic [1:0]       mode,
`ifdef USR_SERIAL_OUT_EN
  output logic             serial_out_left,
  output logic             serial_out_right,
`endif
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // An X/Z mode hits the default arm, so the register goes X in simulation.
  always_comb begin
    w_next = r_q;
    case (mode)
      MODE_HOLD:  w_next = r_q;
      MODE_RIGHT: w_next = {serial_in_right, r_q[WIDTH-1:1]};
      MODE_LEFT:  w_next = {r_q[WIDTH-2:0], serial_in_left};
      MODE_LOAD:  w_next = parallel_load;
      default:    w_next = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

`ifdef USR_SERIAL_OUT_EN
  assign serial_out_left  = r_q[WIDTH-1];
  assign serial_out_right = r_q[0];
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH = 4).
// Cascade taps are also checked when USR_SERIAL_OUT_EN is defined.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic       serialInLeft;
  logic       serialInRight;
  logic [3:0] parallelLoad;
  logic [1:0] mode;
  logic [3:0] q;
`ifdef USR_SERIAL_OUT_EN
  logic       serialOutLeft;
  logic       serialOutRight;
`endif

  int vectors     = 0;
  int miscompares = 0;

  universal_shift_reg #(.WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .serial_in_left  (serialInLeft),
    .serial_in_right (serialInRight),
    .parallel_load   (parallelLoad),
    .mode            (mode),
`ifdef USR_SERIAL_OUT_EN
    .serial_out_left (serialOutLeft),
    .serial_out_right(serialOutRight),
`endif
    .q               (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    vectors++;
    assert (q === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: q observed %b expected %b", tag, q, expected);
    end
`ifdef USR_SERIAL_OUT_EN
    vectors++;
    assert ({serialOutLeft, serialOutRight} === {expected[3], expected[0]}) else begin
      miscompares++;
      $error("[TB] FAIL %s taps: observed %b%b expected %b%b", tag,
             serialOutLeft, serialOutRight, expected[3], expected[0]);
    end
`endif
  endtask

  // Drive one operation, let one rising edge pass, then sample 1 time unit later.
  task automatic applyStimulus(input logic [1:0] m, input logic sl, input logic sr,
                               input logic [3:0] pl, input string tag,
                               input logic [3:0] expected);
    mode          = m;
    serialInLeft  = sl;
    serialInRight = sr;
    parallelLoad  = pl;
    @(posedge clk);
    #1;
    checkOutput(tag, expected);
  endtask

  initial begin
    rst           = 1'b1;
    mode          = 2'b11;
    serialInLeft  = 1'b1;
    serialInRight = 1'b1;
    parallelLoad  = 4'b1111;

    // Reset asserted before any clock edge must clear q asynchronously.
    #2 rst = 1'b0;
    #1 checkOutput("reset_async", 4'b0000);
    applyStimulus(2'b11, 1'b1, 1'b1, 4'b1111, "reset_held_load", 4'b0000);
    applyStimulus(2'b10, 1'b1, 1'b1, 4'b1010, "reset_held_shl", 4'b0000);
    rst = 1'b1;

    applyStimulus(2'b11, 1'b0, 1'b0, 4'b0010, "load_0010", 4'b0010);
    applyStimulus(2'b00, 1'b1, 1'b1, 4'b1111, "hold_0010", 4'b0010);
    applyStimulus(2'b10, 1'b1, 1'b0, 4'b0000, "shl_a", 4'b0101);
    applyStimulus(2'b10, 1'b1, 1'b0, 4'b0000, "shl_b", 4'b1011);
    applyStimulus(2'b01, 1'b1, 1'b0, 4'b1111, "shr_a", 4'b0101);
    applyStimulus(2'b01, 1'b1, 1'b0, 4'b1111, "shr_b", 4'b0010);
    applyStimulus(2'b11, 1'b1, 1'b1, 4'b0110, "load_0110", 4'b0110);
    applyStimulus(2'b01, 1'b0, 1'b1, 4'b0000, "shr_sin1", 4'b1011);
    applyStimulus(2'b10, 1'b0, 1'b1, 4'b0000, "shl_drop_msb", 4'b0110);
    applyStimulus(2'b11, 1'b1, 1'b1, 4'b1001, "load_1001", 4'b1001);
    applyStimulus(2'b00, 1'b0, 1'b0, 4'b0110, "hold_1001", 4'b1001);
    applyStimulus(2'b01, 1'b1, 1'b0, 4'b1111, "shr_drop_lsb", 4'b0100);
    applyStimulus(2'b10, 1'b1, 1'b1, 4'b0000, "shl_before_rst", 4'b1001);

    // Reset between edges while a shift is selected.
    #2 rst = 1'b0;
    #1 checkOutput("reset_midcycle", 4'b0000);
    applyStimulus(2'b10, 1'b1, 1'b1, 4'b1111, "reset_mid_held", 4'b0000);
    rst = 1'b1;
    applyStimulus(2'b10, 1'b1, 1'b0, 4'b1111, "resume_shl", 4'b0001);
    applyStimulus(2'b01, 1'b0, 1'b1, 4'b0000, "resume_shr", 4'b1000);
    applyStimulus(2'b11, 1'b0, 1'b0, 4'b1111, "load_1111", 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
